mem_wb_pipe_stage: RTL

- Parametrised successor to the fixed single-stage memory/writeback register.
- Carries writeback payload (control bits, ALU result, load data, destination register) through STAGES register slots. Adds a valid bit per slot, stall (hold), flush (bubble insertion), a registered writeback-data select, and a saturating bubble counter for performance monitoring.
- Sits between the data-memory stage and the register-file write port.

---
 rtl/mem_wb_pipe_stage.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_wb_pipe_stage.sv
// Memory/writeback pipeline register: STAGES slots of writeback payload with valid,
// stall, flush, pre-selected writeback data and a saturating bubble counter.
`timescale 1ns/1ps
module mem_wb_pipe_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CTRL_WIDTH     = 2,
   parameter int STAGES         = 1,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      stall,
   input  logic                      flush,
   input  logic                      valid_in,
   input  logic [CTRL_WIDTH-1:0]     ctrl_in,
   input  logic [DATA_WIDTH-1:0]     alu_result_in,
   input  logic [DATA_WIDTH-1:0]     read_data_in,
   input  logic [REG_ADDR_WIDTH-1:0] write_reg_in,
   input  logic                      clear_stats,
   output logic                      valid_out,
   output logic [CTRL_WIDTH-1:0]     ctrl_out,
   output logic [DATA_WIDTH-1:0]     alu_result_out,
   output logic [DATA_WIDTH-1:0]     read_data_out,
   output logic [REG_ADDR_WIDTH-1:0] write_reg_out,
   output logic [DATA_WIDTH-1:0]     wb_data_out,
   output logic                      reg_write_out,
   output logic [CNT_WIDTH-1:0]      bubble_count
);

   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("mem_wb_pipe_stage: STAGES must be in the range 1..4");
   end

   if (CTRL_WIDTH < 2) begin : g_bad_ctrl
      $error("mem_wb_pipe_stage: CTRL_WIDTH must be at least 2 (reg_write, mem_to_reg)");
   end

   logic                      r_valid [STAGES];
   logic [CTRL_WIDTH-1:0]     r_ctrl  [STAGES];
   logic [DATA_WIDTH-1:0]     r_alu   [STAGES];
   logic [DATA_WIDTH-1:0]     r_rdata [STAGES];
   logic [REG_ADDR_WIDTH-1:0] r_wreg  [STAGES];
   logic [DATA_WIDTH-1:0]     r_wb    [STAGES];

   logic                      w_src_valid [STAGES];
   logic [CTRL_WIDTH-1:0]     w_src_ctrl  [STAGES];
   logic [DATA_WIDTH-1:0]     w_src_alu   [STAGES];
   logic [DATA_WIDTH-1:0]     w_src_rdata [STAGES];
   logic [REG_ADDR_WIDTH-1:0] w_src_wreg  [STAGES];
   logic [DATA_WIDTH-1:0]     w_src_wb    [STAGES];

   logic [CNT_WIDTH-1:0]      r_bubble_cnt;

   // Slot 0 sources from the memory stage (selecting wb data here); later slots copy their predecessor.
   for (genvar k = 0; k < STAGES; k++) begin : g_src
      if (k == 0) begin : g_head
         assign w_src_valid[k] = valid_in;
         assign w_src_ctrl[k]  = ctrl_in;
         assign w_src_alu[k]   = alu_result_in;
         assign w_src_rdata[k] = read_data_in;
         assign w_src_wreg[k]  = write_reg_in;
         assign w_src_wb[k]    = ctrl_in[1] ? read_data_in : alu_result_in;
      end else begin : g_body
         assign w_src_valid[k] = r_valid[k-1];
         assign w_src_ctrl[k]  = r_ctrl[k-1];
         assign w_src_alu[k]   = r_alu[k-1];
         assign w_src_rdata[k] = r_rdata[k-1];
         assign w_src_wreg[k]  = r_wreg[k-1];
         assign w_src_wb[k]    = r_wb[k-1];
      end
   end

   // NOTE: the data fields are reset along with valid/ctrl so every output reads 0 in reset;
   // a plain datapath register array would normally be left without reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            r_valid[k] <= 1'b0;
            r_ctrl[k]  <= '0;
            r_alu[k]   <= '0;
            r_rdata[k] <= '0;
            r_wreg[k]  <= '0;
            r_wb[k]    <= '0;
         end
      end else if (flush) begin
         for (int k = 0; k < STAGES; k++) begin
            r_valid[k] <= 1'b0;
            r_ctrl[k]  <= '0;
         end
      end else if (!stall) begin
         for (int k = 0; k < STAGES; k++) begin
            r_valid[k] <= w_src_valid[k];
            // A bubble must never carry reg_write, so ctrl is gated by the source valid.
            r_ctrl[k]  <= w_src_ctrl[k] & {CTRL_WIDTH{w_src_valid[k]}};
            r_alu[k]   <= w_src_alu[k];
            r_rdata[k] <= w_src_rdata[k];
            r_wreg[k]  <= w_src_wreg[k];
            r_wb[k]    <= w_src_wb[k];
         end
      end
   end

   // Counts non-stalled cycles where the last slot presents a bubble; clear wins, saturates at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bubble_cnt <= '0;
      end else if (clear_stats) begin
         r_bubble_cnt <= '0;
      end else if (!stall && !r_valid[STAGES-1] && (r_bubble_cnt != {CNT_WIDTH{1'b1}})) begin
         r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
   end

   assign valid_out      = r_valid[STAGES-1];
   assign ctrl_out       = r_ctrl[STAGES-1];
   assign alu_result_out = r_alu[STAGES-1];
   assign read_data_out  = r_rdata[STAGES-1];
   assign write_reg_out  = r_wreg[STAGES-1];
   assign wb_data_out    = r_wb[STAGES-1];
   assign reg_write_out  = r_ctrl[STAGES-1][0] & r_valid[STAGES-1];
   assign bubble_count   = r_bubble_cnt;

endmodule
